pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Parametrised pipeline control for the WISC core. Replaces the fixed 5-stage hazard detector and its
//   scattered stall/flush glue. Tracks every in-flight writer past decode in a valid/dest scoreboard and
//   detects RAW hazards (forwarding-aware). Applies branch/jump redirect flushes at a configurable stage,
//   arbitrates I-mem/D-mem stalls, and keeps saturating stall/flush/retire performance counters.
// PARAMETERS
//   NUM_STAGES  5  total pipe stages (IF,ID + S=NUM_STAGES-2 tracked slots; slot0=EX, slot S-1=WB); >=4
//   REG_W       3  register-specifier width
//   BR_STAGE    1  slot index where redirects resolve (1 = MEM); must be < S
//   FWD_EN      1  1: full EX/MEM forwarding exists, only load-use stalls; 0: no forwarding
//   CNT_W      16  performance-counter width
// PORTS
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   id_valid     in   1      IF/ID holds a real instruction
//   id_rs,id_rt  in   REG_W  decode source registers
//   id_rd_rs     in   1      decode instruction reads rs
//   id_rd_rt     in   1      decode instruction reads rt
//   id_wr        in   1      decode instruction writes a register
//   id_dest      in   REG_W  its destination register
//   id_load      in   1      decode instruction is a load
//   redirect     in   1      instruction in slot BR_STAGE is a taken branch/jump
//   imem_stall   in   1      instruction memory not ready
//   dmem_stall   in   1      data memory not ready
//   pc_we        out  1      PC register write enable
//   ifid_we      out  1      IF/ID latch enable
//   ifid_flush   out  1      load IF/ID as invalid (bubble)
//   idex_bubble  out  1      ID/EX receives a NOP this edge
//   pipe_en      out  1      enable for ID/EX, EX/MEM, MEM/WB latches
//   raw_stall    out  1      RAW hazard detected on the decode instruction
//   slot_valid   out  S      valid bit per tracked slot
//   retire       out  1      instruction leaves WB this edge
//   cnt_stall    out  CNT_W  cycles with any stall
//   cnt_flush    out  CNT_W  accepted redirects
//   cnt_retire   out  CNT_W  retired instructions
// BEHAVIOUR
//   - Per-slot state is {v, wr, dest, load}. Reset clears all v and zeroes all counters (async, immediate).
//     Combinational outputs are then derived from empty slots.
//   - adv = ~dmem_stall. pipe_en = adv. On !adv all slot state holds and counters hold.
//     Exception: cnt_stall increments.
//   - Hazard window: FWD_EN=1: match only slot0 with load=1. FWD_EN=0: any slot 0..S-2.
//     Slot S-1 writes back this cycle and the regfile bypasses it.
//   - raw_stall = id_valid & ~redirect & OR over window of (v & wr & ((id_rd_rs & dest==id_rs) |
//     (id_rd_rt & dest==id_rt))). R0 is a real register, not excluded.
//   - On adv: slot[k] <= slot[k-1] for k>=1. slot0 <= decode entry when
//     id_valid & ~raw_stall & ~redirect; otherwise slot0 is invalid (idex_bubble=1).
//   - Redirect (accepted only when adv): after the edge slots 0..BR_STAGE are invalid.
//     The resolving instruction moves to BR_STAGE+1. Also: ifid_flush=1, pc_we=1, cnt_flush+1.
//     Redirect overrides raw_stall and imem_stall.
//   - pc_we = adv & (redirect | (~raw_stall & ~imem_stall)). ifid_we = adv & (redirect | ~raw_stall).
//   - ifid_flush = adv & (redirect | (imem_stall & ~raw_stall)).
//   - retire = adv & slot[S-1].v. Latency: an unstalled instruction retires S cycles after leaving ID.
//   - cnt_stall += 1 when raw_stall | imem_stall | dmem_stall. All counters saturate at all-ones, no wrap.
//   - redirect held during dmem_stall is acted on in the first cycle dmem_stall is low; the source must hold it.
//   - Reset asserted mid-operation discards all in-flight state. No partial flush.
// TESTING
//   1 Reset with slots full and counters nonzero: assert rst_n=0 -> slot_valid=0 and all counters=0 same cycle.
//   2 FWD_EN=1: load r3 in slot0, ID reads rs=r3 -> raw_stall=1 for 1 cycle, pc_we=0, idex_bubble=1,
//     then issues. cnt_stall=1.
//   3 FWD_EN=0, S=3: ALU writes r2, next instr reads rt=r2 -> 2 stall cycles. Issues when writer reaches slot2.
//   4 BR_STAGE=1, slot_valid=3'b111, redirect=1 -> next slot_valid=3'b100, ifid_flush=1, pc_we=1, cnt_flush+1.
//   5 dmem_stall 3 cycles with redirect held -> slots frozen, pc_we=0 throughout.
//     Flush occurs on the 4th cycle, cnt_stall+=3.
//   6 CNT_W=4: 20 consecutive imem_stall cycles -> cnt_stall=4'hF and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/redirect/stall request bundle and pipeline-control response for pipe_hazard_ctrl.
// The master drives decode and memory status. The slave (the controller) returns the enables and counters.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int S     = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rd_rs;
    logic             id_rd_rt;
    logic             id_wr;
    logic [REG_W-1:0] id_dest;
    logic             id_load;
    logic             redirect;
    logic             imem_stall;
    logic             dmem_stall;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_en;
    logic             raw_stall;
    logic [S-1:0]     slot_valid;
    logic             retire;
    logic [CNT_W-1:0] cnt_stall;
    logic [CNT_W-1:0] cnt_flush;
    logic [CNT_W-1:0] cnt_retire;

    modport master (
        output id_valid, id_rs, id_rt, id_rd_rs, id_rd_rt, id_wr, id_dest, id_load,
               redirect, imem_stall, dmem_stall,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en, raw_stall,
               slot_valid, retire, cnt_stall, cnt_flush, cnt_retire
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd_rs, id_rd_rt, id_wr, id_dest, id_load,
               redirect, imem_stall, dmem_stall,
        output pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en, raw_stall,
               slot_valid, retire, cnt_stall, cnt_flush, cnt_retire
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall/flush controller: scoreboard of in-flight writers past decode,
// forwarding-aware RAW detection, redirect flush at slot BR_STAGE, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int REG_W      = 3,
    parameter int BR_STAGE   = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int S = NUM_STAGES - 2;

    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] dest;
        logic             load;
    } slot_t;

    slot_t [S-1:0]    slot_q, slot_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
    logic [CNT_W-1:0] cnt_retire_q, cnt_retire_d;

    logic         adv;
    logic         raw_stall;
    logic         issue;
    logic         retire;
    logic [S-1:0] hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Slot S-1 is being written back this cycle and the regfile bypasses it, so it never
    // joins the window. With forwarding only a load still in EX cannot be forwarded.
    for (genvar k = 0; k < S; k++) begin : g_slot
        localparam bit IN_WIN = (FWD_EN != 0) ? (k == 0) : (k <= S - 2);
        logic src_match;

        assign src_match = (bus.id_rd_rs && (slot_q[k].dest == bus.id_rs)) ||
                           (bus.id_rd_rt && (slot_q[k].dest == bus.id_rt));
        assign hit[k] = IN_WIN && slot_q[k].v && slot_q[k].wr &&
                        (slot_q[k].load || (FWD_EN == 0)) && src_match;
        assign bus.slot_valid[k] = slot_q[k].v;
    end

    assign adv       = ~bus.dmem_stall;
    assign raw_stall = bus.id_valid & ~bus.redirect & (|hit);
    assign issue     = bus.id_valid & ~raw_stall & ~bus.redirect;
    assign retire    = adv & slot_q[S-1].v;

    assign bus.pipe_en     = adv;
    assign bus.raw_stall   = raw_stall;
    assign bus.retire      = retire;
    assign bus.idex_bubble = adv & ~issue;
    assign bus.pc_we       = adv & (bus.redirect | (~raw_stall & ~bus.imem_stall));
    assign bus.ifid_we     = adv & (bus.redirect | ~raw_stall);
    assign bus.ifid_flush  = adv & (bus.redirect | (bus.imem_stall & ~raw_stall));
    assign bus.cnt_stall   = cnt_stall_q;
    assign bus.cnt_flush   = cnt_flush_q;
    assign bus.cnt_retire  = cnt_retire_q;

    // A redirect kills everything younger than the resolver; the resolver itself shifts on
    // into BR_STAGE+1 like any other instruction.
    always_comb begin
        slot_d = slot_q;
        if (adv) begin
            for (int k = S - 1; k >= 1; k--) slot_d[k] = slot_q[k-1];
            slot_d[0] = '{v: issue, wr: bus.id_wr, dest: bus.id_dest, load: bus.id_load};
            if (bus.redirect) begin
                for (int k = 0; k <= BR_STAGE; k++) slot_d[k].v = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_stall_d  = sat_inc(cnt_stall_q, raw_stall | bus.imem_stall | bus.dmem_stall);
        cnt_flush_d  = sat_inc(cnt_flush_q, adv & bus.redirect);
        cnt_retire_d = sat_inc(cnt_retire_q, retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            cnt_stall_q  <= '0;
            cnt_flush_q  <= '0;
            cnt_retire_q <= '0;
        end else begin
            slot_q       <= slot_d;
            cnt_stall_q  <= cnt_stall_d;
            cnt_flush_q  <= cnt_flush_d;
            cnt_retire_q <= cnt_retire_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding build (u_fwd) and no-forwarding 4-bit-counter build (u_nof).
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(3), .S(3), .CNT_W(16)) a_if ();
    pipe_hazard_ctrl_if #(.REG_W(3), .S(3), .CNT_W(4))  b_if ();

    pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_W(3), .BR_STAGE(1), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_W(3), .BR_STAGE(1), .FWD_EN(0), .CNT_W(4)) u_nof (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sel=0 drives u_fwd, sel=1 drives u_nof
    task automatic id(input bit sel, input logic v, input logic [2:0] rs, input logic [2:0] rt,
                      input logic rrs, input logic rrt, input logic wr,
                      input logic [2:0] dest, input logic ld);
        if (!sel) begin
            a_if.id_valid = v; a_if.id_rs = rs; a_if.id_rt = rt; a_if.id_rd_rs = rrs;
            a_if.id_rd_rt = rrt; a_if.id_wr = wr; a_if.id_dest = dest; a_if.id_load = ld;
        end else begin
            b_if.id_valid = v; b_if.id_rs = rs; b_if.id_rt = rt; b_if.id_rd_rs = rrs;
            b_if.id_rd_rt = rrt; b_if.id_wr = wr; b_if.id_dest = dest; b_if.id_load = ld;
        end
    endtask

    task automatic ctl(input bit sel, input logic redir, input logic imem, input logic dmem);
        if (!sel) begin
            a_if.redirect = redir; a_if.imem_stall = imem; a_if.dmem_stall = dmem;
        end else begin
            b_if.redirect = redir; b_if.imem_stall = imem; b_if.dmem_stall = dmem;
        end
    endtask

    initial begin
        id(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0); ctl(0, 0, 0, 0);
        id(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0); ctl(1, 0, 0, 0);
        #12;
        chk("rst_valid",  32'(a_if.slot_valid), 0);
        chk("rst_cstall", 32'(a_if.cnt_stall), 0);
        chk("rst_pc_we",  32'(a_if.pc_we), 1);
        chk("rst_bubble", 32'(a_if.idex_bubble), 1);
        rst_n = 1'b1;
        step();

        // load-use with forwarding: one stall cycle
        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 1); #1;
        chk("ld_issue_raw", 32'(a_if.raw_stall), 0);
        chk("ld_issue_bub", 32'(a_if.idex_bubble), 0);
        step();
        chk("ld_valid", 32'(a_if.slot_valid), 3'b001);
        id(0, 1, 3'd3, 3'd0, 1, 0, 1, 3'd4, 0); #1;
        chk("lu_raw",     32'(a_if.raw_stall), 1);
        chk("lu_pc_we",   32'(a_if.pc_we), 0);
        chk("lu_ifid_we", 32'(a_if.ifid_we), 0);
        chk("lu_bubble",  32'(a_if.idex_bubble), 1);
        chk("lu_flush",   32'(a_if.ifid_flush), 0);
        step();
        chk("lu_valid1", 32'(a_if.slot_valid), 3'b010);
        chk("lu_cstall", 32'(a_if.cnt_stall), 1);
        #1;
        chk("lu_raw2",   32'(a_if.raw_stall), 0);
        chk("lu_pc_we2", 32'(a_if.pc_we), 1);
        step();
        chk("lu_valid2", 32'(a_if.slot_valid), 3'b101);

        // ALU producer in slot0 is forwarded: no stall
        id(0, 1, 3'd0, 3'd4, 0, 1, 1, 3'd5, 0); #1;
        chk("alu_fwd_raw", 32'(a_if.raw_stall), 0);
        chk("retire_ld",   32'(a_if.retire), 1);
        step();
        chk("alu_valid",  32'(a_if.slot_valid), 3'b011);
        chk("cretire1",   32'(a_if.cnt_retire), 1);

        // load to r0 then a reader of r0: r0 is a real register
        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd0, 1); #1;
        chk("ld_r0_raw", 32'(a_if.raw_stall), 0);
        step();
        chk("full_valid", 32'(a_if.slot_valid), 3'b111);
        id(0, 1, 3'd0, 3'd0, 0, 1, 0, 3'd0, 0); #1;
        chk("r0_raw", 32'(a_if.raw_stall), 1);

        // redirect with all slots full overrides the stall
        ctl(0, 1, 0, 0); #1;
        chk("br_raw",     32'(a_if.raw_stall), 0);
        chk("br_pc_we",   32'(a_if.pc_we), 1);
        chk("br_flush",   32'(a_if.ifid_flush), 1);
        chk("br_ifid_we", 32'(a_if.ifid_we), 1);
        chk("br_bubble",  32'(a_if.idex_bubble), 1);
        step();
        chk("br_valid",   32'(a_if.slot_valid), 3'b100);
        chk("br_cflush",  32'(a_if.cnt_flush), 1);
        chk("br_cstall",  32'(a_if.cnt_stall), 1);
        chk("br_cretire", 32'(a_if.cnt_retire), 2);
        ctl(0, 0, 0, 0);

        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd6, 0);
        step();
        chk("p_valid1",  32'(a_if.slot_valid), 3'b001);
        chk("cretire3",  32'(a_if.cnt_retire), 3);
        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd7, 0);
        step();
        chk("p_valid2", 32'(a_if.slot_valid), 3'b011);

        // dmem stall for 3 cycles with redirect held: freeze, then flush
        ctl(0, 1, 0, 1);
        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dm_pc_we",  32'(a_if.pc_we), 0);
            chk("dm_pipe",   32'(a_if.pipe_en), 0);
            chk("dm_flush",  32'(a_if.ifid_flush), 0);
            chk("dm_retire", 32'(a_if.retire), 0);
            step();
            chk("dm_valid", 32'(a_if.slot_valid), 3'b011);
        end
        chk("dm_cstall", 32'(a_if.cnt_stall), 4);
        chk("dm_cflush", 32'(a_if.cnt_flush), 1);
        ctl(0, 1, 0, 0); #1;
        chk("dm4_pc_we", 32'(a_if.pc_we), 1);
        chk("dm4_flush", 32'(a_if.ifid_flush), 1);
        step();
        chk("dm4_valid",  32'(a_if.slot_valid), 3'b100);
        chk("dm4_cflush", 32'(a_if.cnt_flush), 2);
        chk("dm4_cstall", 32'(a_if.cnt_stall), 4);
        ctl(0, 0, 0, 0);
        id(0, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0);
        step();
        chk("drain_valid",   32'(a_if.slot_valid), 3'b000);
        chk("drain_cretire", 32'(a_if.cnt_retire), 4);

        // no forwarding: ALU writer blocks until it reaches the last slot
        id(1, 1, 3'd0, 3'd0, 0, 0, 1, 3'd2, 0);
        step();
        chk("nf_valid0", 32'(b_if.slot_valid), 3'b001);
        id(1, 1, 3'd0, 3'd2, 0, 1, 1, 3'd1, 0); #1;
        chk("nf_raw0",   32'(b_if.raw_stall), 1);
        chk("nf_pc_we0", 32'(b_if.pc_we), 0);
        step();
        chk("nf_valid1", 32'(b_if.slot_valid), 3'b010);
        chk("nf_raw1",   32'(b_if.raw_stall), 1);
        step();
        chk("nf_valid2", 32'(b_if.slot_valid), 3'b100);
        chk("nf_raw2",   32'(b_if.raw_stall), 0);
        chk("nf_bub2",   32'(b_if.idex_bubble), 0);
        chk("nf_retire", 32'(b_if.retire), 1);
        step();
        chk("nf_valid3", 32'(b_if.slot_valid), 3'b001);
        chk("nf_cstall", 32'(b_if.cnt_stall), 2);
        id(1, 0, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0);

        // 4-bit stall counter saturates under a long imem stall
        ctl(1, 0, 1, 0); #1;
        chk("im_pc_we", 32'(b_if.pc_we), 0);
        chk("im_flush", 32'(b_if.ifid_flush), 1);
        for (int i = 0; i < 20; i++) step();
        chk("sat_cstall", 32'(b_if.cnt_stall), 4'hF);
        step();
        chk("sat_hold", 32'(b_if.cnt_stall), 4'hF);
        ctl(1, 0, 0, 0);

        // reset mid-operation with slots full and counters nonzero
        id(0, 1, 3'd0, 3'd0, 0, 0, 1, 3'd2, 0);
        step(); step(); step();
        chk("pre_rst_valid", 32'(a_if.slot_valid), 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid",   32'(a_if.slot_valid), 0);
        chk("mrst_cstall",  32'(a_if.cnt_stall), 0);
        chk("mrst_cflush",  32'(a_if.cnt_flush), 0);
        chk("mrst_cretire", 32'(a_if.cnt_retire), 0);
        chk("mrst_b_cstall", 32'(b_if.cnt_stall), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
